fmt_int_serializer: RTL
=======================

// Module: fmt_int_serializer
// PURPOSE
//  Parametrised, sequential integer formatter: converts one WIDTH-bit value to ASCII
//  in decimal, hex, octal or binary (%d/%h/%o/%b semantics) with optional sign and zero padding.
//  Streams the result one character per beat over a valid/ready interface.
//  Sits between a value producer and string/log sinks.
//  Replaces combinational $sformatf use with synthesizable, width-generic RTL.
// PARAMETERS
//  WIDTH      32  bit width of in_value (>=2)
//  HEX_UPPER  0   1: hex digits 'A'-'F'; 0: 'a'-'f'
//  MAXD       = WIDTH (derived localparam) digit buffer depth; binary worst case
// PORTS
//  clk           in   1                   clock, all logic on rising edge
//  rst           in   1                   synchronous reset, active-high
//  in_valid      in   1                   request valid
//  in_ready      out  1                   request accepted when in_valid&&in_ready
//  in_value      in   WIDTH               value to format
//  in_radix      in   2                   0=dec 1=hex 2=oct 3=bin
//  in_signed     in   1                   dec only: in_value is two's complement
//  in_min_digits in   $clog2(WIDTH+1)     zero-pad to this many digits; sign excluded
//  out_valid     out  1                   out_char valid
//  out_ready     in   1                   sink accepts when out_valid&&out_ready
//  out_char      out  8                   ASCII character
//  out_last      out  1                   marks final character of the string
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, out_last=0, out_char=8'h00, digit count=0.
//  Reset mid-CONVERT/EMIT aborts the string; no out_last is produced; next cycle is IDLE.
//  FSM: IDLE -(accept)-> CONVERT -(done)-> EMIT -(last beat accepted)-> IDLE.
//   in_ready=1 only in IDLE; request fields are latched on accept.
//  Radix / sign rules:
//   - Magnitude = |in_value| iff radix=dec && in_signed && MSB=1, else raw bits.
//   - -2^(WIDTH-1) yields magnitude 2^(WIDTH-1), unsigned; no overflow.
//   - in_signed is ignored for hex/oct/bin.
//   - Octal: top digit takes the remaining WIDTH%3 bits.
//  Effective minimum = max(1, min(in_min_digits, MAXD)).
//  CONVERT produces digits LSB-first into the buffer; per-digit cycle cost:
//   - hex/oct/bin: 1 cycle, shift by 4/3/1.
//   - dec, remaining value !=0: WIDTH cycles; bit-serial restoring divide by 10,
//     one quotient bit per cycle; remainder is the digit.
//   - any radix, remaining value ==0: 1 cycle, digit '0' (padding, or a zero value).
//  CONVERT ends after a digit when remaining value==0 and digit count >= effective minimum.
//  EMIT begins the next cycle. Sign '-' (if negative) is emitted first, then pad zeros,
//  then digits MSB-first.
//  EMIT: out_valid held high; out_char/out_last stable while out_valid&&!out_ready.
//   Advances one char per accepted beat; out_last=1 only on the final char.
//   After the last accept: out_valid=0 and in_ready=1 the next cycle.
//   No zero-length strings; minimum output is "0".
// TESTING
//  WIDTH=8, hex, 0x2A, min 0, out_ready=1: accept @c0, CONVERT c1-c2,
//   out "2","a" @c3,c4 with last @c4; in_ready=1 @c5.
//  WIDTH=8, dec, signed, 0x80: "-128", last on '8'.
//   Dec 42 unsigned: CONVERT 16 cycles, then "42".
//  WIDTH=8, dec, 7, min 4: "0007". Signed -7, min 3: "-007" (4 beats).
//   Min 15 clamps to 8 digits.
//  WIDTH=8, bin, 0, min 0: single "0" with out_last; oct 0xFF: "377";
//   HEX_UPPER=1, 0xAB: "AB".
//  Backpressure: out_ready low 5 cycles mid-string; out_char/out_last hold;
//   no char dropped or duplicated.
//   in_valid held during EMIT is not accepted until IDLE.
//  Assert rst for 1 cycle mid-EMIT: next cycle out_valid=0, in_ready=1, no out_last.
//   A new request then formats correctly.

Source files
------------

// File: rtl/fmt_int_serializer.sv
// rtl/fmt_int_serializer.sv - sequential integer-to-ASCII formatter (dec/hex/oct/bin) streaming one char per beat
module fmt_int_serializer #(
  parameter int WIDTH     = 32,
  parameter bit HEX_UPPER = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_value,
  input  logic [1:0]                   in_radix,
  input  logic                         in_signed,
  input  logic [$clog2(WIDTH+1)-1:0]   in_min_digits,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_char,
  output logic                         out_last
);

  localparam int MAXD = WIDTH;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int AW   = $clog2(MAXD);
  localparam int BW   = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_EMIT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_val;
  logic [1:0]       r_radix;
  logic             r_neg;
  logic [CW-1:0]    r_min;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_idx;
  logic [BW-1:0]    r_bcnt;
  logic [3:0]       r_rem;
  logic [3:0]       r_buf [MAXD];

  logic             w_neg;
  logic [WIDTH-1:0] w_mag;
  logic [CW-1:0]    w_min_eff;
  logic [4:0]       w_div_in;
  logic             w_ge;
  logic [3:0]       w_div_sub;
  logic [3:0]       w_digit;
  logic             w_digit_ok;
  logic [WIDTH-1:0] w_val_nxt;
  logic [3:0]       w_rem_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_done;
  logic [CW-1:0]    w_rd_idx;
  logic [3:0]       w_rd_digit;

  function automatic logic [7:0] f_ascii(input logic [3:0] d);
    if (d < 4'd10) return 8'h30 + {4'h0, d};
    return (HEX_UPPER ? 8'h37 : 8'h57) + {4'h0, d};
  endfunction

  assign w_neg = (in_radix == 2'd0) && in_signed && in_value[WIDTH-1];
  assign w_mag = w_neg ? -in_value : in_value;

  always_comb begin
    w_min_eff = in_min_digits;
    if (in_min_digits == '0)
      w_min_eff = CW'(1);
    else if (in_min_digits > CW'(MAXD))
      w_min_eff = CW'(MAXD);
  end

  // Restoring divide by 10: r_val shifts left, quotient bits enter at the LSB.
  assign w_div_in  = {r_rem, r_val[WIDTH-1]};
  assign w_ge      = (w_div_in >= 5'd10);
  assign w_div_sub = 4'(w_div_in - 5'd10);

  always_comb begin
    w_digit    = 4'd0;
    w_digit_ok = 1'b0;
    w_val_nxt  = r_val;
    w_rem_nxt  = r_rem;
    if (r_val == '0 && r_bcnt == '0) begin
      w_digit_ok = 1'b1;
    end else begin
      case (r_radix)
        2'd1: begin
          w_digit    = 4'(r_val);
          w_val_nxt  = r_val >> 4;
          w_digit_ok = 1'b1;
        end
        2'd2: begin
          w_digit    = {1'b0, 3'(r_val)};
          w_val_nxt  = r_val >> 3;
          w_digit_ok = 1'b1;
        end
        2'd3: begin
          w_digit    = {3'b000, r_val[0]};
          w_val_nxt  = r_val >> 1;
          w_digit_ok = 1'b1;
        end
        default: begin
          w_rem_nxt = w_ge ? w_div_sub : w_div_in[3:0];
          w_val_nxt = {r_val[WIDTH-2:0], w_ge};
          if (r_bcnt == BW'(WIDTH - 1)) begin
            w_digit_ok = 1'b1;
            w_digit    = w_rem_nxt;
          end
        end
      endcase
    end
  end

  assign w_cnt_nxt  = r_cnt + 1'b1;
  assign w_done     = w_digit_ok && (w_val_nxt == '0) && (w_cnt_nxt >= r_min);
  assign w_rd_idx   = r_idx - 1'b1;
  assign w_rd_digit = r_buf[w_rd_idx[AW-1:0]];

  always_ff @(posedge clk) begin
    if (r_state == S_CONVERT && w_digit_ok)
      r_buf[r_cnt[AW-1:0]] <= w_digit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_char  <= 8'h00;
      r_val     <= '0;
      r_radix   <= 2'd0;
      r_neg     <= 1'b0;
      r_min     <= CW'(1);
      r_cnt     <= '0;
      r_idx     <= '0;
      r_bcnt    <= '0;
      r_rem     <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_val    <= w_mag;
            r_radix  <= in_radix;
            r_neg    <= w_neg;
            r_min    <= w_min_eff;
            r_cnt    <= '0;
            r_bcnt   <= '0;
            r_rem    <= 4'd0;
            in_ready <= 1'b0;
            r_state  <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          r_val  <= w_val_nxt;
          r_rem  <= w_digit_ok ? 4'd0 : w_rem_nxt;
          r_bcnt <= w_digit_ok ? '0 : r_bcnt + 1'b1;
          if (w_digit_ok)
            r_cnt <= w_cnt_nxt;
          // The digit finishing conversion is the most significant one, so it leads the string.
          if (w_done) begin
            r_state   <= S_EMIT;
            out_valid <= 1'b1;
            if (r_neg) begin
              out_char <= 8'h2d;
              out_last <= 1'b0;
              r_idx    <= w_cnt_nxt;
            end else begin
              out_char <= f_ascii(w_digit);
              out_last <= (r_cnt == '0);
              r_idx    <= r_cnt;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              out_char <= f_ascii(w_rd_digit);
              out_last <= (w_rd_idx == '0);
              r_idx    <= w_rd_idx;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
